// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encodings and default sizing.
// Default sizing sweeps 16 vectors with one-cycle settle.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_SETTLE = 1;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a combinational circuit, captures its truth table and grades it.
// done rises 2**N_IN*SETTLE edges after the start edge; start is ignored while sweeping.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                                N_IN   = DEF_N_IN,
  parameter int                                SETTLE = DEF_SETTLE,
  parameter logic [vec_count(N_IN)-1:0]        EXPECT = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [N_IN-1:0]             x_out,
  input  logic                        y_in,
  output logic                        busy,
  output logic                        done,
  output logic [vec_count(N_IN)-1:0]  table_out,
  output logic [N_IN:0]               mismatch_cnt,
  output logic [N_IN-1:0]             first_fail,
  output logic                        first_fail_vld,
  output logic                        pass
);

  localparam int NV = vec_count(N_IN);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [NV-1:0]     table_q, table_d;
  logic [N_IN:0]     mism_q, mism_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              ffv_q, ffv_d;

  logic start_ok;
  logic sample;
  logic last_vec;

  assign start_ok = start && (state_q != ST_RUN);
  assign sample   = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign last_vec = (x_q == VEC_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if (sample && last_vec) state_d = ST_DONE;
      ST_DONE: if (start_ok) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        done = 1'b1;
        pass = (mism_q == '0);
      end
      default: ;
    endcase
  end

  // Datapath: settle counter, vector counter and result accumulation
  always_comb begin
    cnt_d   = cnt_q;
    x_d     = x_q;
    table_d = table_q;
    mism_d  = mism_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    if (start_ok) begin
      cnt_d   = '0;
      x_d     = '0;
      table_d = '0;
      mism_d  = '0;
      ff_d    = '0;
      ffv_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (sample) begin
        table_d[x_q] = y_in;
        if (y_in != EXPECT[x_q]) begin
          mism_d = mism_q + {{N_IN{1'b0}}, 1'b1};
          if (!ffv_q) begin
            ff_d  = x_q;
            ffv_d = 1'b1;
          end
        end
        cnt_d = '0;
        // The last vector stays on x_out so the circuit output remains observable in DONE.
        if (!last_vec) begin
          x_d = x_q + {{(N_IN-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      x_q     <= '0;
      table_q <= '0;
      mism_q  <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      table_q <= table_d;
      mism_q  <= mism_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  assign x_out          = x_q;
  assign table_out      = table_q;
  assign mismatch_cnt   = mism_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule
